// File: rtl/gary_cycle_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : gary_cycle_ctl
//  Purpose  : Table-driven 68000 address decoder and bus-cycle controller
//             (C14M domain), with ROM overlay and per-region wait states.
//  Option   : GARY_CYCLE_TIMEOUT_EN adds a bus-error timeout and BERR state.
//  Revision : 1.0  initial release
// ============================================================================
module gary_cycle_ctl #(
    parameter int ADDR_W = 8,
    parameter int NREG   = 8,
    parameter int WS_W   = 4,
    parameter logic [NREG*ADDR_W-1:0] REGION_BASE = 64'hD0C0_E0F8_DEDC_B000,
    parameter logic [NREG*ADDR_W-1:0] REGION_MASK = 64'hF8F0_F8F8_FEFE_F0E0,
    parameter logic [NREG*WS_W-1:0]   REGION_WS   = 32'h0000_0600,
    parameter logic [NREG*2-1:0]      REGION_KIND = 16'h5F49,
    parameter int ROM_IDX = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              C14M,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] A,
    input  logic              nAS,
    input  logic              PRnW,
    input  logic              nUDS,
    input  logic              nLDS,
    input  logic              OVL,
    input  logic              XRDY,
    input  logic              nDBR,
    input  logic              nOVR,
    output logic [NREG-1:0]   nSEL,
    output logic              nDTACK,
    output logic              nVPA,
    output logic              nBLS,
    output logic              nBERR,
    output logic              BUSY
);

    localparam logic [1:0] c_KIND_FAST = 2'd0;
    localparam logic [1:0] c_KIND_CHIP = 2'd1;
    localparam logic [1:0] c_KIND_VPA  = 2'd2;
    localparam logic [1:0] c_KIND_ROM  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_DMAHOLD = 3'd2,
        S_ACK     = 3'd3,
`ifdef GARY_CYCLE_TIMEOUT_EN
        S_BERR    = 3'd5,
`endif
        S_OVRD    = 3'd4
    } state_t;

    state_t            r_state;
    logic [NREG-1:0]   r_nSel;
    logic              r_nDtack;
    logic              r_nVpa;
    logic              r_nBls;
    logic              r_busy;
    logic              r_armed;
    logic              r_unmapped;
    logic [WS_W-1:0]   r_cnt;
    logic [1:0]        r_kind;

    logic              w_hit;
    logic [NREG-1:0]   w_sel;
    logic [WS_W-1:0]   w_ws;
    logic [1:0]        w_kind;
    logic              w_start;

`ifdef GARY_CYCLE_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT + 1);
    logic [c_TMO_W-1:0] r_tmo;
    logic               r_nBerr;
    assign nBERR = r_nBerr;
`else
    assign nBERR = 1'b1;
`endif

    // Scan from the top index down so the lowest matching region wins.
    always_comb begin
        w_hit  = 1'b0;
        w_sel  = '0;
        w_ws   = '0;
        w_kind = c_KIND_FAST;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (((A ^ REGION_BASE[i*ADDR_W +: ADDR_W]) & REGION_MASK[i*ADDR_W +: ADDR_W]) == '0) begin
                w_hit    = 1'b1;
                w_sel    = '0;
                w_sel[i] = 1'b1;
                w_ws     = REGION_WS[i*WS_W +: WS_W];
                w_kind   = REGION_KIND[i*2 +: 2];
            end
        end
        if (OVL && (A[ADDR_W-1 -: 3] == 3'b000)) begin
            w_hit          = 1'b1;
            w_sel          = '0;
            w_sel[ROM_IDX] = 1'b1;
            w_ws           = REGION_WS[ROM_IDX*WS_W +: WS_W];
            w_kind         = REGION_KIND[ROM_IDX*2 +: 2];
        end
    end

    // Reads start on the address strobe alone; writes also need a data strobe.
    assign w_start = !nAS && r_armed && (PRnW || !nUDS || !nLDS);

    always_ff @(posedge C14M) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_nSel     <= '1;
            r_nDtack   <= 1'b1;
            r_nVpa     <= 1'b1;
            r_nBls     <= 1'b1;
            r_busy     <= 1'b0;
            r_armed    <= 1'b0;
            r_unmapped <= 1'b0;
            r_cnt      <= '0;
            r_kind     <= c_KIND_FAST;
`ifdef GARY_CYCLE_TIMEOUT_EN
            r_nBerr    <= 1'b1;
            r_tmo      <= '0;
`endif
        end else if ((r_state != S_IDLE) && nAS) begin
            r_state    <= S_IDLE;
            r_nSel     <= '1;
            r_nDtack   <= 1'b1;
            r_nVpa     <= 1'b1;
            r_nBls     <= 1'b1;
            r_busy     <= 1'b0;
            r_armed    <= 1'b1;
            r_unmapped <= 1'b0;
`ifdef GARY_CYCLE_TIMEOUT_EN
            r_nBerr    <= 1'b1;
`endif
        end else begin
            if (nAS) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        if (!nOVR) begin
                            r_state <= S_OVRD;
                        end else begin
                            r_state    <= S_WAIT;
                            r_busy     <= 1'b1;
                            r_cnt      <= w_ws;
                            r_kind     <= w_kind;
                            r_unmapped <= !w_hit;
`ifdef GARY_CYCLE_TIMEOUT_EN
                            r_tmo      <= '0;
`endif
                            if (w_hit && !((w_kind == c_KIND_ROM) && !PRnW)) begin
                                r_nSel <= ~w_sel;
                            end
                            if (w_hit && (w_kind == c_KIND_CHIP)) begin
                                r_nBls <= 1'b0;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (!r_unmapped && (r_cnt == '0) && XRDY) begin
                        if ((r_kind == c_KIND_CHIP) && !nDBR) begin
                            r_state <= S_DMAHOLD;
                        end else begin
                            r_state <= S_ACK;
                            r_nBls  <= 1'b1;
                        end
                    end
`ifdef GARY_CYCLE_TIMEOUT_EN
                    else if (r_tmo == c_TMO_W'(TIMEOUT)) begin
                        r_state <= S_BERR;
                        r_nBerr <= 1'b0;
                        r_nBls  <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DMAHOLD: begin
                    if (nDBR) begin
                        r_state <= S_ACK;
                        r_nBls  <= 1'b1;
                    end
`ifdef GARY_CYCLE_TIMEOUT_EN
                    else if (r_tmo == c_TMO_W'(TIMEOUT)) begin
                        r_state <= S_BERR;
                        r_nBerr <= 1'b0;
                        r_nBls  <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end
                S_ACK: begin
                    if (r_kind == c_KIND_VPA) begin
                        r_nVpa <= 1'b0;
                    end else begin
                        r_nDtack <= 1'b0;
                    end
                end
`ifdef GARY_CYCLE_TIMEOUT_EN
                S_BERR: begin
                    r_nBerr  <= 1'b0;
                    r_nDtack <= 1'b1;
                end
`endif
                S_OVRD: begin
                    r_state <= S_OVRD;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign nSEL   = r_nSel;
    assign nDTACK = r_nDtack;
    assign nVPA   = r_nVpa;
    assign nBLS   = r_nBls;
    assign BUSY   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_gary_cycle_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gary_cycle_ctl
//  Purpose  : Scoreboard bench for gary_cycle_ctl with directed bus cycles.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gary_cycle_ctl;

    logic       C14M = 1'b0;
    logic       RESET;
    logic [7:0] A;
    logic       nAS, PRnW, nUDS, nLDS, OVL, XRDY, nDBR, nOVR;
    logic [7:0] nSEL;
    logic       nDTACK, nVPA, nBLS, nBERR, BUSY;

    gary_cycle_ctl dut (
        .C14M   (C14M),
        .RESET  (RESET),
        .A      (A),
        .nAS    (nAS),
        .PRnW   (PRnW),
        .nUDS   (nUDS),
        .nLDS   (nLDS),
        .OVL    (OVL),
        .XRDY   (XRDY),
        .nDBR   (nDBR),
        .nOVR   (nOVR),
        .nSEL   (nSEL),
        .nDTACK (nDTACK),
        .nVPA   (nVPA),
        .nBLS   (nBLS),
        .nBERR  (nBERR),
        .BUSY   (BUSY)
    );

    always #5 C14M = ~C14M;

    int cyc = 0;
    always @(posedge C14M) cyc <= cyc + 1;

    int          nChecks = 0;
    int          nPass   = 0;
    int          qCyc[$];
    logic [12:0] qExp[$];
    string       qName[$];

    wire [12:0] obs = {nSEL, nDTACK, nVPA, nBLS, nBERR, BUSY};

    function automatic logic [12:0] mk(logic [7:0] sel, logic dt, logic vpa, logic bls, logic busy);
        return {sel, dt, vpa, bls, 1'b1, busy};
    endfunction

    localparam logic [12:0] c_IDLE = {8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    function automatic void pushExp(int c, logic [12:0] v, string nm);
        qCyc.push_back(c);
        qExp.push_back(v);
        qName.push_back(nm);
    endfunction

    // Monitor: compare every expectation due at the edge just taken.
    always @(negedge C14M) begin
        while (qCyc.size() > 0 && qCyc[0] <= cyc) begin
            int          c;
            logic [12:0] v;
            string       nm;
            c  = qCyc.pop_front();
            v  = qExp.pop_front();
            nm = qName.pop_front();
            nChecks++;
            if (obs === v) nPass++;
            else $display("FAIL %s edge %0d: got {nSEL,nDTACK,nVPA,nBLS,nBERR,BUSY}=%b want %b",
                          nm, c, obs, v);
        end
    end

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge C14M);
    endtask

    task automatic startCycle(input logic [7:0] addr, input logic rnw, output int e0);
        @(negedge C14M);
        A = addr; PRnW = rnw; nUDS = 1'b0; nLDS = 1'b0; nAS = 1'b0;
        e0 = cyc + 1;
    endtask

    task automatic endAt(input int target, input string nm);
        waitUntil(target);
        nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; PRnW = 1'b1;
        pushExp(cyc + 1, c_IDLE, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int e0;
        int guard;
        RESET = 1'b1; A = 8'h00; nAS = 1'b1; PRnW = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        OVL = 1'b0; XRDY = 1'b1; nDBR = 1'b1; nOVR = 1'b1;
        repeat (3) @(negedge C14M);
        pushExp(cyc + 1, c_IDLE, "reset");
        @(negedge C14M);
        RESET = 1'b0;
        repeat (2) @(negedge C14M);

        // Chip RAM read, zero wait states
        startCycle(8'h00, 1'b1, e0);
        pushExp(e0,     mk(8'hFE, 1, 1, 0, 1), "chip_sel");
        pushExp(e0 + 1, mk(8'hFE, 1, 1, 1, 1), "chip_bls_rel");
        pushExp(e0 + 2, mk(8'hFE, 0, 1, 1, 1), "chip_dtack");
        pushExp(e0 + 3, mk(8'hFE, 0, 1, 1, 1), "chip_hold");
        endAt(e0 + 3, "chip_end");

        // RTC, six wait states
        startCycle(8'hDC, 1'b1, e0);
        pushExp(e0,     mk(8'hFB, 1, 1, 1, 1), "rtc_sel");
        pushExp(e0 + 7, mk(8'hFB, 1, 1, 1, 1), "rtc_ws");
        pushExp(e0 + 8, mk(8'hFB, 0, 1, 1, 1), "rtc_dtack");
        endAt(e0 + 8, "rtc_end");

        // RTC with XRDY low for three edges at cnt==0
        startCycle(8'hDC, 1'b1, e0);
        pushExp(e0 + 8,  mk(8'hFB, 1, 1, 1, 1), "xrdy_stall8");
        pushExp(e0 + 10, mk(8'hFB, 1, 1, 1, 1), "xrdy_stall10");
        pushExp(e0 + 11, mk(8'hFB, 0, 1, 1, 1), "xrdy_dtack");
        waitUntil(e0 + 6);
        XRDY = 1'b0;
        waitUntil(e0 + 9);
        XRDY = 1'b1;
        endAt(e0 + 11, "xrdy_end");

        // CIA access via VPA
        startCycle(8'hBF, 1'b1, e0);
        pushExp(e0 + 1, mk(8'hFD, 1, 1, 1, 1), "cia_e1");
        pushExp(e0 + 2, mk(8'hFD, 1, 0, 1, 1), "cia_vpa");
        endAt(e0 + 2, "cia_end");

        // ROM overlay at address 0
        OVL = 1'b1;
        startCycle(8'h00, 1'b1, e0);
        pushExp(e0,     mk(8'hEF, 1, 1, 1, 1), "ovl_sel");
        pushExp(e0 + 2, mk(8'hEF, 0, 1, 1, 1), "ovl_dtack");
        endAt(e0 + 2, "ovl_end");
        OVL = 1'b0;

        // Chip cycle held off by DMA for ten edges
        nDBR = 1'b0;
        startCycle(8'h00, 1'b1, e0);
        pushExp(e0,      mk(8'hFE, 1, 1, 0, 1), "dma_sel");
        pushExp(e0 + 5,  mk(8'hFE, 1, 1, 0, 1), "dma_hold");
        pushExp(e0 + 9,  mk(8'hFE, 1, 1, 0, 1), "dma_hold9");
        pushExp(e0 + 10, mk(8'hFE, 1, 1, 1, 1), "dma_ack");
        pushExp(e0 + 11, mk(8'hFE, 0, 1, 1, 1), "dma_dtack");
        pushExp(e0 + 12, mk(8'hFE, 0, 1, 1, 1), "dma_late_dbr");
        waitUntil(e0 + 9);
        nDBR = 1'b1;
        waitUntil(e0 + 11);
        nDBR = 1'b0;
        endAt(e0 + 12, "dma_end");
        nDBR = 1'b1;

        // ROM write: no select, still acknowledged
        startCycle(8'hF8, 1'b0, e0);
        pushExp(e0,     mk(8'hFF, 1, 1, 1, 1), "romwr_nosel");
        pushExp(e0 + 2, mk(8'hFF, 0, 1, 1, 1), "romwr_dtack");
        endAt(e0 + 2, "romwr_end");

        // Reset in the middle of an RTC wait; nAS low must then be ignored
        startCycle(8'hDC, 1'b1, e0);
        pushExp(e0 + 4, c_IDLE, "rst_mid");
        pushExp(e0 + 5, c_IDLE, "rst_armed5");
        pushExp(e0 + 6, c_IDLE, "rst_armed6");
        waitUntil(e0 + 3);
        RESET = 1'b1;
        waitUntil(e0 + 4);
        RESET = 1'b0;
        endAt(e0 + 6, "rst_end");

        startCycle(8'h00, 1'b1, e0);
        pushExp(e0 + 2, mk(8'hFE, 0, 1, 1, 1), "post_rst_dtack");
        endAt(e0 + 2, "post_rst_end");

        // Override: nothing driven
        nOVR = 1'b0;
        startCycle(8'h00, 1'b1, e0);
        pushExp(e0,     c_IDLE, "ovr_e0");
        pushExp(e0 + 2, c_IDLE, "ovr_e2");
        endAt(e0 + 3, "ovr_end");
        nOVR = 1'b1;

        // nAS high on the edge where cnt reaches zero wins
        startCycle(8'hDC, 1'b1, e0);
        pushExp(e0 + 6, mk(8'hFB, 1, 1, 1, 1), "prio_pre");
        endAt(e0 + 6, "prio_end");
        pushExp(e0 + 8, c_IDLE, "prio_after");
        waitUntil(e0 + 8);

        // Write without data strobes does not start a cycle
        @(negedge C14M);
        A = 8'h00; PRnW = 1'b0; nUDS = 1'b1; nLDS = 1'b1; nAS = 1'b0;
        e0 = cyc + 1;
        pushExp(e0,     c_IDLE, "nods_e0");
        pushExp(e0 + 1, c_IDLE, "nods_e1");
        endAt(e0 + 1, "nods_end");

        // Unmapped address stays in WAIT, no bus error in this build
        startCycle(8'h80, 1'b1, e0);
        pushExp(e0,      mk(8'hFF, 1, 1, 1, 1), "unm_e0");
        pushExp(e0 + 30, mk(8'hFF, 1, 1, 1, 1), "unm_e30");
        endAt(e0 + 30, "unm_end");

        guard = 0;
        while (qCyc.size() > 0 && guard < 100) begin
            @(negedge C14M);
            guard++;
        end
        if (qCyc.size() > 0) begin
            nChecks++;
            $display("FAIL drain: %0d expectations pending, required 0", qCyc.size());
        end
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
